// File: rtl/iob_cache_ctrl_master_if.sv
// Command/response and IOB request signals of the cache control master.
// master = the controller's view, slave = the command source plus the IOB target.
interface iob_cache_ctrl_master_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic [1:0]            cmd_op_i;
  logic [ADDR_W-1:0]     cmd_addr_i;
  logic [7:0]            cmd_wdata_i;
  logic                  rsp_valid_o;
  logic [DATA_W-1:0]     rsp_data_o;
  logic                  rsp_err_o;
  logic                  iob_valid_o;
  logic [ADDR_W-1:0]     iob_addr_o;
  logic [DATA_W-1:0]     iob_wdata_o;
  logic [DATA_W/8-1:0]   iob_wstrb_o;
  logic [DATA_W-1:0]     iob_rdata_i;
  logic                  iob_ready_i;

  modport master (
    input  cmd_valid_i, cmd_op_i, cmd_addr_i, cmd_wdata_i, iob_rdata_i, iob_ready_i,
    output cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
    output iob_valid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o
  );

  modport slave (
    output cmd_valid_i, cmd_op_i, cmd_addr_i, cmd_wdata_i, iob_rdata_i, iob_ready_i,
    input  cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
    input  iob_valid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o
  );
endinterface

// File: rtl/iob_cache_ctrl_master.sv
// IOB initiator for the cache control port: single CSR read/write plus FLUSH_INVALIDATE.
// Define IOB_CACHE_CTRL_MASTER_STATS_EN to enable the flush/poll statistics counters.
module iob_cache_ctrl_master #(
  parameter int                DATA_W          = 32,
  parameter int                ADDR_W          = 5,
  parameter logic [ADDR_W-1:0] WTB_EMPTY_ADDR  = 5'h04,
  parameter logic [ADDR_W-1:0] INVALIDATE_ADDR = 5'h01,
  parameter int                MAX_POLL        = 1024,
  parameter int                RSP_TIMEOUT     = 64
) (
  input  logic                    clk_i,
  input  logic                    cke_i,
  input  logic                    arst_i,
  iob_cache_ctrl_master_if.master bus,
  output logic                    busy_o,
  output logic [DATA_W-1:0]       flush_cnt_o,
  output logic [DATA_W-1:0]       poll_cnt_o
);
  localparam int STRB_W = DATA_W / 8;
  localparam int TMR_W  = $clog2(RSP_TIMEOUT + 1);
  localparam int PCNT_W = $clog2(MAX_POLL + 1);
  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_FLUSH = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;
  localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(STRB_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_CHECK, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic                inval_q, inval_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [PCNT_W-1:0]   polls_q, polls_d;

  logic                req_write;
  logic [ADDR_W-1:0]   req_addr;
  logic [7:0]          req_byte;
  logic [ADDR_W-1:0]   req_lane;

  // FLUSH reuses the REQ/WAIT path: poll phase is a WTB_EMPTY read, then the invalidate write
  always_comb begin
    req_write = (op_q == OP_WRITE) || ((op_q == OP_FLUSH) && inval_q);
    req_addr  = addr_q;
    if (op_q == OP_FLUSH) req_addr = inval_q ? INVALIDATE_ADDR : WTB_EMPTY_ADDR;
    req_byte  = (op_q == OP_FLUSH) ? 8'h01 : wdata_q;
    req_lane  = req_addr & LANE_MASK;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= S_IDLE;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      inval_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      tmr_q   <= '0;
      polls_q <= '0;
    end else if (cke_i) begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      inval_q <= inval_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      tmr_q   <= tmr_d;
      polls_q <= polls_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    inval_d = inval_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    tmr_d   = tmr_q;
    polls_d = polls_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid_i) begin
          op_d    = bus.cmd_op_i;
          addr_d  = bus.cmd_addr_i;
          wdata_d = bus.cmd_wdata_i;
          inval_d = 1'b0;
          rdata_d = '0;
          polls_d = '0;
          tmr_d   = '0;
          err_d   = (bus.cmd_op_i == OP_RSVD);
          state_d = (bus.cmd_op_i == OP_RSVD) ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        tmr_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // The REQ cycle counts toward the timeout, so the limit here is RSP_TIMEOUT-2
        if (bus.iob_ready_i) begin
          if (!req_write) rdata_d = bus.iob_rdata_i;
          state_d = S_CHECK;
        end else if (tmr_q == TMR_W'(RSP_TIMEOUT - 2)) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_CHECK: begin
        state_d = S_RESP;
        if ((op_q == OP_FLUSH) && !inval_q) begin
          if (rdata_q[0]) begin
            inval_d = 1'b1;
            state_d = S_REQ;
          end else begin
            polls_d = polls_q + 1'b1;
            if (polls_d == PCNT_W'(MAX_POLL)) err_d = 1'b1;
            else                              state_d = S_REQ;
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pulses are qualified by cke_i so a stalled clock never presents a repeated handshake
  always_comb begin
    bus.cmd_ready_o = (state_q == S_IDLE) && cke_i;
    bus.iob_valid_o = (state_q == S_REQ) && cke_i;
    bus.iob_addr_o  = '0;
    bus.iob_wstrb_o = '0;
    bus.iob_wdata_o = '0;
    if (state_q == S_REQ) begin
      bus.iob_addr_o = req_addr;
      if (req_write) begin
        bus.iob_addr_o  = req_addr & ~LANE_MASK;
        bus.iob_wstrb_o = STRB_W'(1) << req_lane;
        bus.iob_wdata_o = {STRB_W{req_byte}};
      end
    end
    bus.rsp_valid_o = (state_q == S_RESP) && cke_i;
    bus.rsp_err_o   = (state_q == S_RESP) && err_q;
    bus.rsp_data_o  = ((state_q == S_RESP) && (op_q != OP_WRITE)) ? rdata_q : '0;
    busy_o          = (state_q != S_IDLE);
  end

`ifdef IOB_CACHE_CTRL_MASTER_STATS_EN
  logic [DATA_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [DATA_W-1:0] poll_cnt_q, poll_cnt_d;

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    poll_cnt_d  = poll_cnt_q;
    if ((state_q == S_WAIT) && bus.iob_ready_i && (op_q == OP_FLUSH) && !inval_q)
      poll_cnt_d = poll_cnt_q + 1'b1;
    if ((state_q == S_RESP) && (op_q == OP_FLUSH) && !err_q)
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      flush_cnt_q <= '0;
      poll_cnt_q  <= '0;
    end else if (cke_i) begin
      flush_cnt_q <= flush_cnt_d;
      poll_cnt_q  <= poll_cnt_d;
    end
  end

  assign flush_cnt_o = flush_cnt_q;
  assign poll_cnt_o  = poll_cnt_q;
`else
  assign flush_cnt_o = '0;
  assign poll_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_iob_cache_ctrl_master.sv
// Directed bench for iob_cache_ctrl_master with a small cke-aware IOB slave model.
module tb_iob_cache_ctrl_master;
  logic clk = 1'b0;
  logic cke = 1'b1;
  logic arst = 1'b1;
  always #5 clk = ~clk;

`ifdef IOB_CACHE_CTRL_MASTER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  iob_cache_ctrl_master_if #(.DATA_W(32), .ADDR_W(5)) bus ();
  logic        busy;
  logic [31:0] flush_cnt, poll_cnt;

  iob_cache_ctrl_master #(
    .DATA_W(32), .ADDR_W(5), .WTB_EMPTY_ADDR(5'h04), .INVALIDATE_ADDR(5'h01),
    .MAX_POLL(4), .RSP_TIMEOUT(64)
  ) dut (
    .clk_i(clk), .cke_i(cke), .arst_i(arst), .bus(bus),
    .busy_o(busy), .flush_cnt_o(flush_cnt), .poll_cnt_o(poll_cnt)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // slave model controls (written by the initial block only)
  logic        ack_en = 1'b1;
  logic [31:0] rd_tbl [0:7];
  int          rd_base = 0;

  // slave/monitor observations (written by the always blocks only)
  int          rd_cnt = 0, wr_cnt = 0, vld_cnt = 0, req_cyc = 0;
  logic [4:0]  last_addr;
  logic [3:0]  last_strb;
  logic [31:0] last_wdata;
  int          rsp_cnt = 0, rsp_cyc = 0, acc_cyc = 0;
  logic [31:0] rsp_data;
  logic        rsp_err;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge arst) begin
    if (arst) begin
      bus.iob_ready_i <= 1'b0;
      bus.iob_rdata_i <= '0;
    end else if (cke) begin
      bus.iob_ready_i <= 1'b0;
      bus.iob_rdata_i <= '0;
      if (bus.iob_valid_o) begin
        vld_cnt    <= vld_cnt + 1;
        req_cyc    <= cyc;
        last_addr  <= bus.iob_addr_o;
        last_strb  <= bus.iob_wstrb_o;
        last_wdata <= bus.iob_wdata_o;
        if (bus.iob_wstrb_o == 4'b0) rd_cnt <= rd_cnt + 1;
        else                         wr_cnt <= wr_cnt + 1;
        if (ack_en) begin
          bus.iob_ready_i <= 1'b1;
          if (bus.iob_wstrb_o == 4'b0) bus.iob_rdata_i <= rd_tbl[(rd_cnt - rd_base) & 7];
        end
      end
    end
  end

  always @(posedge clk) begin
    if (!arst && cke) begin
      if (bus.cmd_valid_i && bus.cmd_ready_o) acc_cyc <= cyc;
      if (bus.rsp_valid_o) begin
        rsp_cnt  <= rsp_cnt + 1;
        rsp_cyc  <= cyc;
        rsp_data <= bus.rsp_data_o;
        rsp_err  <= bus.rsp_err_o;
      end
    end
  end

  // Issue one command and wait for its response; cke_gap>0 stalls the clock early in WAIT
  task automatic do_cmd(input logic [1:0] op, input logic [4:0] addr, input logic [7:0] wd,
                        input int cke_gap);
    int n;
    int start;
    start = rsp_cnt;
    @(negedge clk);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_op_i    = op;
    bus.cmd_addr_i  = addr;
    bus.cmd_wdata_i = wd;
    n = 0;
    while (!bus.cmd_ready_o && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (n == 50) begin errors++; $display("FAIL accept: got ready=0 required ready=1"); end
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    if (cke_gap > 0) begin
      @(negedge clk);
      cke = 1'b0;
      repeat (cke_gap) @(negedge clk);
      cke = 1'b1;
    end
    n = 0;
    while (rsp_cnt == start && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (n == 300) begin errors++; $display("FAIL rsp_timeout: got no response required one"); end
    $display("txn op=%0d addr=%02h wdata=%02h -> data=%08h err=%0b lat=%0d",
             op, addr, wd, rsp_data, rsp_err, rsp_cyc - acc_cyc);
  endtask

  task automatic test_reset();
    #1;
    checks++; if (bus.cmd_ready_o !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready: got %b required 1", bus.cmd_ready_o); end
    checks++; if (bus.iob_valid_o !== 1'b0) begin errors++; $display("FAIL rst_iob_valid: got %b required 0", bus.iob_valid_o); end
    checks++; if (bus.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b required 0", bus.rsp_valid_o); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
    checks++; if (bus.iob_wstrb_o !== 4'h0) begin errors++; $display("FAIL rst_wstrb: got %h required 0", bus.iob_wstrb_o); end
    checks++; if (flush_cnt !== 32'h0 || poll_cnt !== 32'h0) begin errors++; $display("FAIL rst_stats: got %0d/%0d required 0/0", flush_cnt, poll_cnt); end
  endtask

  task automatic test_read();
    int v0;
    v0 = vld_cnt; rd_base = rd_cnt; rd_tbl[0] = 32'h1;
    do_cmd(2'd0, 5'h04, 8'h00, 0);
    checks++; if (vld_cnt - v0 !== 1) begin errors++; $display("FAIL read_pulses: got %0d required 1", vld_cnt - v0); end
    checks++; if (last_strb !== 4'h0) begin errors++; $display("FAIL read_wstrb: got %h required 0", last_strb); end
    checks++; if (last_addr !== 5'h04) begin errors++; $display("FAIL read_addr: got %h required 04", last_addr); end
    checks++; if (rsp_cyc - acc_cyc !== 4) begin errors++; $display("FAIL read_latency: got %0d required 4", rsp_cyc - acc_cyc); end
    checks++; if (rsp_data !== 32'h1 || rsp_err !== 1'b0) begin errors++; $display("FAIL read_rsp: got %h/%b required 1/0", rsp_data, rsp_err); end
  endtask

  task automatic test_write();
    do_cmd(2'd1, 5'h01, 8'h01, 0);
    checks++; if (last_addr !== 5'h00) begin errors++; $display("FAIL wr1_addr: got %h required 00", last_addr); end
    checks++; if (last_strb !== 4'b0010) begin errors++; $display("FAIL wr1_strb: got %b required 0010", last_strb); end
    checks++; if (last_wdata !== 32'h01010101) begin errors++; $display("FAIL wr1_wdata: got %h required 01010101", last_wdata); end
    checks++; if (rsp_err !== 1'b0 || rsp_data !== 32'h0) begin errors++; $display("FAIL wr1_rsp: got %h/%b required 0/0", rsp_data, rsp_err); end
    do_cmd(2'd1, 5'h06, 8'hA5, 0);
    checks++; if (last_addr !== 5'h04) begin errors++; $display("FAIL wr2_addr: got %h required 04", last_addr); end
    checks++; if (last_strb !== 4'b0100) begin errors++; $display("FAIL wr2_strb: got %b required 0100", last_strb); end
    checks++; if (last_wdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL wr2_wdata: got %h required a5a5a5a5", last_wdata); end
  endtask

  task automatic test_flush_ok();
    int r0, w0;
    r0 = rd_cnt; w0 = wr_cnt; rd_base = rd_cnt;
    rd_tbl[0] = 32'h0; rd_tbl[1] = 32'h0; rd_tbl[2] = 32'h1;
    do_cmd(2'd2, 5'h00, 8'h00, 0);
    checks++; if (rd_cnt - r0 !== 3) begin errors++; $display("FAIL flush_polls: got %0d required 3", rd_cnt - r0); end
    checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL flush_writes: got %0d required 1", wr_cnt - w0); end
    checks++; if (last_addr !== 5'h00 || last_strb !== 4'b0010 || last_wdata !== 32'h01010101) begin
      errors++; $display("FAIL flush_inval: got %h/%b/%h required 00/0010/01010101", last_addr, last_strb, last_wdata); end
    checks++; if (rsp_err !== 1'b0 || rsp_data !== 32'h1) begin errors++; $display("FAIL flush_rsp: got %h/%b required 1/0", rsp_data, rsp_err); end
    #1;
    checks++; if (flush_cnt !== (STATS ? 32'd1 : 32'd0)) begin errors++; $display("FAIL flush_cnt: got %0d required %0d", flush_cnt, STATS ? 1 : 0); end
    checks++; if (poll_cnt !== (STATS ? 32'd3 : 32'd0)) begin errors++; $display("FAIL poll_cnt: got %0d required %0d", poll_cnt, STATS ? 3 : 0); end
  endtask

  task automatic test_flush_exhaust();
    int r0, w0;
    r0 = rd_cnt; w0 = wr_cnt; rd_base = rd_cnt;
    for (int i = 0; i < 8; i++) rd_tbl[i] = 32'h2;
    do_cmd(2'd2, 5'h00, 8'h00, 0);
    checks++; if (rd_cnt - r0 !== 4) begin errors++; $display("FAIL exh_polls: got %0d required 4", rd_cnt - r0); end
    checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL exh_writes: got %0d required 0", wr_cnt - w0); end
    checks++; if (rsp_err !== 1'b1 || rsp_data !== 32'h2) begin errors++; $display("FAIL exh_rsp: got %h/%b required 2/1", rsp_data, rsp_err); end
    #1;
    checks++; if (poll_cnt !== (STATS ? 32'd7 : 32'd0) || flush_cnt !== (STATS ? 32'd1 : 32'd0)) begin
      errors++; $display("FAIL exh_stats: got %0d/%0d required %0d/%0d", flush_cnt, poll_cnt, STATS ? 1 : 0, STATS ? 7 : 0); end
  endtask

  task automatic test_timeout_reserved();
    int v0;
    ack_en = 1'b0; v0 = vld_cnt;
    do_cmd(2'd0, 5'h04, 8'h00, 0);
    checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL tmo_err: got %b required 1", rsp_err); end
    checks++; if (rsp_cyc - req_cyc !== 64) begin errors++; $display("FAIL tmo_cycles: got %0d required 64", rsp_cyc - req_cyc); end
    checks++; if (vld_cnt - v0 !== 1) begin errors++; $display("FAIL tmo_pulses: got %0d required 1", vld_cnt - v0); end
    ack_en = 1'b1; v0 = vld_cnt;
    do_cmd(2'd3, 5'h04, 8'h00, 0);
    checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL rsvd_err: got %b required 1", rsp_err); end
    checks++; if (vld_cnt - v0 !== 0) begin errors++; $display("FAIL rsvd_pulses: got %0d required 0", vld_cnt - v0); end
    checks++; if (rsp_cyc - acc_cyc !== 1) begin errors++; $display("FAIL rsvd_latency: got %0d required 1", rsp_cyc - acc_cyc); end
  endtask

  task automatic test_cke_stall();
    rd_base = rd_cnt; rd_tbl[0] = 32'hCAFE0001;
    do_cmd(2'd0, 5'h08, 8'h00, 10);
    checks++; if (rsp_cyc - acc_cyc !== 14) begin errors++; $display("FAIL cke_latency: got %0d required 14", rsp_cyc - acc_cyc); end
    checks++; if (rsp_data !== 32'hCAFE0001 || rsp_err !== 1'b0) begin errors++; $display("FAIL cke_rsp: got %h/%b required cafe0001/0", rsp_data, rsp_err); end
  endtask

  task automatic test_arst_mid();
    int r0;
    ack_en = 1'b0; r0 = rsp_cnt;
    @(negedge clk);
    bus.cmd_valid_i = 1'b1; bus.cmd_op_i = 2'd0; bus.cmd_addr_i = 5'h04;
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL arst_pre_busy: got %b required 1", busy); end
    arst = 1'b1;
    #1;
    checks++; if (bus.iob_valid_o !== 1'b0 || busy !== 1'b0 || bus.cmd_ready_o !== 1'b1) begin
      errors++; $display("FAIL arst_outputs: got valid=%b busy=%b ready=%b required 0/0/1", bus.iob_valid_o, busy, bus.cmd_ready_o); end
    repeat (2) @(negedge clk);
    arst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (rsp_cnt !== r0) begin errors++; $display("FAIL arst_no_rsp: got %0d required %0d", rsp_cnt, r0); end
    checks++; if (flush_cnt !== 32'h0 || poll_cnt !== 32'h0) begin errors++; $display("FAIL arst_stats: got %0d/%0d required 0/0", flush_cnt, poll_cnt); end
    ack_en = 1'b1; rd_base = rd_cnt; rd_tbl[0] = 32'h12345678;
    do_cmd(2'd0, 5'h0C, 8'h00, 0);
    checks++; if (rsp_data !== 32'h12345678 || rsp_err !== 1'b0 || rsp_cyc - acc_cyc !== 4) begin
      errors++; $display("FAIL arst_recover: got %h/%b/%0d required 12345678/0/4", rsp_data, rsp_err, rsp_cyc - acc_cyc); end
  endtask

  initial begin
    bus.cmd_valid_i = 1'b0;
    bus.cmd_op_i    = 2'd0;
    bus.cmd_addr_i  = 5'h0;
    bus.cmd_wdata_i = 8'h0;
    for (int i = 0; i < 8; i++) rd_tbl[i] = 32'h0;
    repeat (2) @(negedge clk);
    test_reset();
    @(negedge clk);
    arst = 1'b0;
    repeat (2) @(negedge clk);
    test_read();
    test_write();
    test_flush_ok();
    test_flush_exhaust();
    test_timeout_reserved();
    test_cke_stall();
    test_arst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/iob_cache_ctrl_master.md
Name: iob_cache_ctrl_master

Overview:
IOB initiator that drives the cache control/CSR port on behalf of a local command source: a CPU-side sequencer, debug unit or boot ROM.
Accepts single-register read/write commands and a compound FLUSH_INVALIDATE command. FLUSH_INVALIDATE polls the write-through-buffer-empty status, then issues the invalidate write.
Sits between the command source and the cache's control IOB slave port. Enforces the single-pulse-request / delayed-ready handshake that the slave implements.

Parameters:
DATA_W, 32, IOB data width; power of two, >= 8.
ADDR_W, 5, IOB CSR byte-address width.
WTB_EMPTY_ADDR, 5'h04, byte address of write-through-buffer-empty status (bit 0 = empty).
INVALIDATE_ADDR, 5'h01, byte address of invalidate CSR (write-only, 1-byte).
MAX_POLL, 1024, max WTB_EMPTY reads before FLUSH_INVALIDATE aborts; >= 1.
RSP_TIMEOUT, 64, max cycles waiting for iob_ready_i per transaction; >= 2.

Ports:
clk_i  in  1  clock
cke_i  in  1  clock enable; all state holds when low
arst_i  in  1  reset, asynchronous, active-high
cmd_valid_i  in  1  command request
cmd_ready_o  out  1  command accepted when cmd_valid_i & cmd_ready_o
cmd_op_i  in  2  0=READ, 1=WRITE, 2=FLUSH_INVALIDATE, 3=reserved
cmd_addr_i  in  ADDR_W  CSR byte address (READ/WRITE only)
cmd_wdata_i  in  8  write byte (WRITE only)
rsp_valid_o  out  1  one-cycle completion pulse
rsp_data_o  out  DATA_W  read data (READ), last poll value (FLUSH), 0 (WRITE)
rsp_err_o  out  1  qualifies rsp_valid_o: timeout, poll exhaustion or reserved op
iob_valid_o  out  1  request pulse to slave
iob_addr_o  out  ADDR_W  request address
iob_wdata_o  out  DATA_W  write data
iob_wstrb_o  out  DATA_W/8  byte strobes; 0 = read
iob_rdata_i  in  DATA_W  slave read data, valid with iob_ready_i
iob_ready_i  in  1  slave acknowledge
busy_o  out  1  high whenever FSM not IDLE
flush_cnt_o  out  DATA_W  completed successful flushes (see Optional Feature)
poll_cnt_o  out  DATA_W  cumulative WTB_EMPTY polls (see Optional Feature)

Behaviour:
- Reset: FSM=IDLE. All outputs 0 except cmd_ready_o=1. Internal counters 0.
- Reset mid-transaction: immediate abort, no response, iob_valid_o drops asynchronously.
- States: IDLE, REQ, WAIT, CHECK, RESP.
- IDLE: cmd_ready_o=1. On accept, latch op/addr/wdata.
  - op 3: go RESP with err=1, no IOB traffic.
  - Otherwise: go REQ, loading the transaction (FLUSH loads a WTB_EMPTY read).
- REQ: iob_valid_o=1 for exactly one cycle, then WAIT. Never hold valid >1 cycle: the slave acks each valid cycle.
- Read request: iob_addr_o=addr, iob_wstrb_o=0, iob_wdata_o=0.
- Write request:
  - iob_addr_o = addr with low log2(DATA_W/8) bits cleared.
  - iob_wstrb_o = one-hot at lane addr[low bits].
  - wdata byte replicated to all lanes.
  - INVALIDATE write: addr=INVALIDATE_ADDR, data 8'h01.
- WAIT: timeout counter cleared on REQ.
  - iob_ready_i: capture iob_rdata_i, go CHECK.
  - Counter reaches RSP_TIMEOUT without ready: go RESP, err=1.
  - iob_ready_i in IDLE/REQ is ignored.
- CHECK:
  - READ/WRITE: go RESP.
  - FLUSH poll phase:
    - rdata[0]=1: load INVALIDATE write, go REQ.
    - Else poll_count+1. poll_count==MAX_POLL: RESP err=1. Otherwise go REQ with a new poll.
  - FLUSH invalidate phase done: RESP.
- RESP: rsp_valid_o=1 one cycle, rsp_data_o/rsp_err_o valid same cycle; then IDLE, cmd_ready_o=1 next cycle.
- Latency, READ with 1-cycle slave: accept edge → REQ → WAIT (ready) → CHECK → RESP; rsp_valid_o is 4 cycles after accept.
- cmd_valid_i while busy: ignored (cmd_ready_o=0); the source must hold it.

Optional Feature:
IOB_CACHE_CTRL_MASTER_STATS_EN
- Defined: flush_cnt_o increments on each error-free FLUSH completion. poll_cnt_o increments on each WTB_EMPTY read ack. Both wrap modulo 2^DATA_W and reset only by arst_i.
- Undefined: both outputs constant 0, counters not instantiated.

Test Plan:
- READ addr 5'h04, slave acks after 1 cycle with 32'h1 → iob_valid_o high exactly 1 cycle, wstrb 0; rsp_valid_o 4 cycles after accept, rsp_data_o=1, err=0.
- WRITE addr 5'h01, data 8'h01, DATA_W=32 → iob_addr_o=5'h00, iob_wstrb_o=4'b0010, iob_wdata_o=32'h01010101; rsp err=0.
- FLUSH, WTB_EMPTY returns 0,0,1 → three read pulses, then one write at INVALIDATE_ADDR; rsp err=0, data=1. STATS_EN: flush_cnt_o=1, poll_cnt_o=3.
- FLUSH, MAX_POLL=4, empty never set → exactly 4 reads, no invalidate write, rsp err=1.
- Slave never acks, RSP_TIMEOUT=64 → rsp_valid_o with err=1 64 cycles after request; cmd_op 3 → err=1 with zero IOB pulses.
- arst_i pulsed during WAIT → outputs at reset values; next READ completes normally; cke_i low 10 cycles mid-WAIT extends latency by 10.
